// File: rtl/lector_display_hexadecimal.sv
// Seven-segment bus reader: samples the multiplexed digit-select/segment lines,
// waits for each digit's pattern to settle, maps it back to its nibble and
// assembles a full word with a one-cycle valid pulse once every digit is seen.
module lector_display_hexadecimal #(
  parameter int N_DIGITOS = 4,
  parameter int ESTABLE   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_DIGITOS-1:0]     Anodo,
  input  logic [6:0]               Hexadecimal,
  output logic [4*N_DIGITOS-1:0]   Valor,
  output logic                     Valido,
  output logic                     Error,
  output logic [N_DIGITOS-1:0]     Capturados
);

  localparam int SW = N_DIGITOS + 7;
  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam logic [3:0] EST = 4'(ESTABLE);

  typedef enum logic [1:0] {ESPERA, ESTABILIZANDO, CAPTURADO} estado_t;

  estado_t                 estado_q, estado_d;
  logic [SW-1:0]           s_q, s_d;      // current sample {Anodo,Hexadecimal}
  logic [SW-1:0]           p_q, p_d;      // previous sample, stability reference
  logic [3:0]              c_q, c_d;      // consecutive-identical-sample count
  logic [4*N_DIGITOS-1:0]  valor_q, valor_d;
  logic                    valido_q, valido_d;
  logic                    error_q, error_d;
  logic [N_DIGITOS-1:0]    capt_q, capt_d;

  logic [N_DIGITOS-1:0]    anodo_s;
  logic [6:0]              seg_s;
  logic                    one_hot;
  logic [IW-1:0]           idx;
  logic                    legal;
  logic [3:0]              nib;
  logic                    captura;
  logic [N_DIGITOS-1:0]    capt_n;

  assign anodo_s = s_q[SW-1:7];
  assign seg_s   = s_q[6:0];

  // Segment pattern back to nibble; anything outside the 16 glyphs is illegal.
  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (seg_s)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // One-hot detection of the sampled select and the index of its set bit.
  always_comb begin
    one_hot = (anodo_s != '0) && ((anodo_s & (anodo_s - 1'b1)) == '0);
    idx     = '0;
    for (int i = 0; i < N_DIGITOS; i++)
      if (anodo_s[i]) idx = IW'(i);
  end

  // Stability counter, state and capture/frame assembly.
  always_comb begin
    s_d      = {Anodo, Hexadecimal};
    p_d      = s_q;
    c_d      = c_q;
    valor_d  = valor_q;
    valido_d = 1'b0;
    error_d  = 1'b0;
    capt_d   = capt_q;
    capt_n   = capt_q;

    if (!one_hot)
      c_d = 4'd0;
    else if (s_q != p_q)
      c_d = 4'd1;
    else if (c_q < EST)
      c_d = c_q + 4'd1;

    if (!one_hot)
      estado_d = ESPERA;
    else if (c_d == EST)
      estado_d = CAPTURADO;
    else
      estado_d = ESTABILIZANDO;

    // Capture only on entry to CAPTURADO; holding the same sample does nothing.
    captura = (estado_d == CAPTURADO) && (estado_q != CAPTURADO);

    if (captura) begin
      if (legal) begin
        valor_d[4*idx +: 4] = nib;
        capt_n[idx]         = 1'b1;
        if (&capt_n) begin
          valido_d = 1'b1;
          capt_d   = '0;
        end else begin
          capt_d = capt_n;
        end
      end else begin
        error_d     = 1'b1;
        capt_d[idx] = 1'b0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= ESPERA;
      s_q      <= '0;
      p_q      <= '0;
      c_q      <= 4'd0;
      valor_q  <= '0;
      valido_q <= 1'b0;
      error_q  <= 1'b0;
      capt_q   <= '0;
    end else begin
      estado_q <= estado_d;
      s_q      <= s_d;
      p_q      <= p_d;
      c_q      <= c_d;
      valor_q  <= valor_d;
      valido_q <= valido_d;
      error_q  <= error_d;
      capt_q   <= capt_d;
    end
  end

  assign Valor      = valor_q;
  assign Valido     = valido_q;
  assign Error      = error_q;
  assign Capturados = capt_q;

endmodule

// File: tb/tb_lector_display_hexadecimal.sv
// Directed bench: expected Valido/Error pulses (with word and cycle) are queued
// as stimulus is driven and popped by a monitor when the DUT pulses.
module tb_lector_display_hexadecimal;

  localparam int N = 4;
  localparam int E = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  anodo;
  logic [6:0]    hex;
  logic [4*N-1:0] valor;
  logic          valido, error;
  logic [N-1:0]  capt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit          err;
    logic [15:0] v;
    int          c;
  } ev_t;
  ev_t q[$];

  lector_display_hexadecimal #(.N_DIGITOS(N), .ESTABLE(E)) dut (
    .clk(clk), .rst(rst), .Anodo(anodo), .Hexadecimal(hex),
    .Valor(valor), .Valido(valido), .Error(error), .Capturados(capt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one select/pattern for n edges; optionally queue the pulse it must cause.
  task automatic hold(input logic [3:0] a, input logic [6:0] h, input int n,
                      input bit ev, input bit err, input logic [15:0] v);
    anodo = a;
    hex   = h;
    if (ev) q.push_back('{err, v, cyc + E + 1});
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (valido === 1'b1 || error === 1'b1) begin
      ev_t e;
      chk("pulse_exclusive", {31'd0, valido & error}, 32'd0);
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse observed valido=%0b error=%0b cyc=%0d expected none",
               valido, error, cyc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pulse_kind_error", {31'd0, error}, {31'd0, e.err});
        chk("pulse_valor", {16'd0, valor}, {16'd0, e.v});
        chk("pulse_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    anodo = 4'b0001;
    hex   = 7'h06;
    // Reset held with active inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_valor", {16'd0, valor}, 32'd0);
      chk("rst_valido", {31'd0, valido}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_capt", {28'd0, capt}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valor", {16'd0, valor}, 32'd0);
    chk("post_rst_capt", {28'd0, capt}, 32'd0);
    hold(4'b0000, 7'h00, 4, 0, 0, '0);

    // Full frame 0123
    hold(4'b0001, 7'h4F, 6, 0, 0, '0);
    chk("frame_capt0", {28'd0, capt}, 32'b0001);
    chk("frame_valor0", {16'd0, valor}, 32'h0003);
    hold(4'b0010, 7'h5B, 6, 0, 0, '0);
    chk("frame_capt1", {28'd0, capt}, 32'b0011);
    chk("frame_valor1", {16'd0, valor}, 32'h0023);
    hold(4'b0100, 7'h06, 6, 0, 0, '0);
    chk("frame_capt2", {28'd0, capt}, 32'b0111);
    hold(4'b1000, 7'h3F, 6, 1, 0, 16'h0123);
    chk("frame_capt_clear", {28'd0, capt}, 32'd0);
    chk("frame_valor", {16'd0, valor}, 32'h0123);

    // Glitch shorter than ESTABLE, then stable 8
    hold(4'b0001, 7'h06, 3, 0, 0, '0);
    hold(4'b0001, 7'h7F, 5, 0, 0, '0);
    chk("glitch_valor", {16'd0, valor}, 32'h0128);
    chk("glitch_capt", {28'd0, capt}, 32'b0001);

    // Illegal blank pattern on digit 2
    hold(4'b0010, 7'h06, 6, 0, 0, '0);
    chk("illegal_pre_capt", {28'd0, capt}, 32'b0011);
    hold(4'b0100, 7'h00, 5, 1, 1, 16'h0118);
    chk("illegal_capt", {28'd0, capt}, 32'b0011);
    chk("illegal_valor", {16'd0, valor}, 32'h0118);

    // Non-one-hot selects never capture
    hold(4'b0110, 7'h7F, 10, 0, 0, '0);
    hold(4'b0000, 7'h7F, 10, 0, 0, '0);
    chk("nonhot_capt", {28'd0, capt}, 32'b0011);
    chk("nonhot_valor", {16'd0, valor}, 32'h0118);

    // Overwrite digits 0-1, add digit 2, then reset mid-frame
    hold(4'b0001, 7'h77, 6, 0, 0, '0);
    hold(4'b0010, 7'h7C, 6, 0, 0, '0);
    hold(4'b0100, 7'h39, 6, 0, 0, '0);
    chk("overwrite_capt", {28'd0, capt}, 32'b0111);
    chk("overwrite_valor", {16'd0, valor}, 32'h0CBA);
    anodo = 4'b0000;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_capt", {28'd0, capt}, 32'd0);
    chk("midrst_valor", {16'd0, valor}, 32'd0);
    hold(4'b1000, 7'h79, 6, 0, 0, '0);
    chk("after_midrst_capt", {28'd0, capt}, 32'b1000);
    chk("after_midrst_valor", {16'd0, valor}, 32'hE000);

    hold(4'b0000, 7'h00, 8, 0, 0, '0);
    chk("pending_events", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
